// File: rtl/mtr_pkg.sv
// Shared types and helpers for the motor PWM driver (pwm_mtr_drv / mtr_chan).
package mtr_pkg;

  localparam int DEF_MAG_W = 11;

  typedef logic signed [DEF_MAG_W-1:0] drv_t;
  typedef logic        [DEF_MAG_W-2:0] mag_t;

  typedef enum logic [2:0] {
    OFF  = 3'd0,
    FWD  = 3'd1,
    REV  = 3'd2,
    BRK  = 3'd3,
    DEAD = 3'd4
  } mtr_state_t;

  // |v| clipped to the largest positive value of a w-bit signed word, so the
  // most negative drive maps to full scale instead of wrapping to zero.
  function automatic logic [31:0] sat_abs(input logic signed [31:0] v, input int unsigned w);
    logic [31:0] lim;
    logic [31:0] a;
    lim = (32'd1 << (w - 1)) - 32'd1;
    a   = v[31] ? 32'(-v) : 32'(v);
    return (a > lim) ? lim : a;
  endfunction

endpackage

// File: rtl/mtr_chan.sv
// One motor channel: pending/active drive, optional slew limit, direction FSM
// with dead time, registered H-bridge outputs. Slew limit built with SLEW_LIMIT_EN.
module mtr_chan
  import mtr_pkg::*;
#(
  parameter int MAG_W     = 11,
  parameter int DEAD_CYC  = 8,
  parameter int SLEW_STEP = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [MAG_W-2:0] cnt,
  input  logic             wrap,
  input  logic [MAG_W-1:0] drv,
  input  logic             drv_vld,
  input  logic             brake,
  output logic             fwd,
  output logic             rev
);

  localparam int DT_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEAD_CYC - 1);

  logic signed [MAG_W-1:0] pending;
  logic signed [MAG_W-1:0] active;
  logic signed [MAG_W-1:0] active_nxt;
  logic [31:0]             mag;
  logic                    pwm_on;
  mtr_state_t              state;
  mtr_state_t              state_nxt;
  mtr_state_t              target;
  logic [DT_W-1:0]         dead_cnt;

  // NOTE: every flop in the channel is reset; there is no memory array here,
  // so no state can come out of reset undefined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      active  <= '0;
    end else begin
      if (drv_vld) pending <= drv;
      if (wrap)    active  <= active_nxt;
    end
  end

`ifdef SLEW_LIMIT_EN
  localparam int XW = MAG_W + 2;
  localparam logic signed [XW-1:0] STEP = XW'(SLEW_STEP);

  logic signed [XW-1:0] act_x;
  logic signed [XW-1:0] pend_x;
  logic signed [XW-1:0] diff;
  logic signed [XW-1:0] stepped;

  // Result always lies between active and pending, so it never leaves the
  // MAG_W range; a step that would jump across zero lands on zero first.
  always_comb begin
    act_x  = XW'(active);
    pend_x = XW'(pending);
    diff   = pend_x - act_x;
    if (diff > STEP)       stepped = act_x + STEP;
    else if (diff < -STEP) stepped = act_x - STEP;
    else                   stepped = pend_x;
    if ((act_x > 0 && stepped < 0) || (act_x < 0 && stepped > 0)) stepped = '0;
    active_nxt = MAG_W'(stepped);
  end
`else
  assign active_nxt = pending;
`endif

  assign mag    = sat_abs(32'(active), MAG_W);
  assign pwm_on = (32'(cnt) < mag);

  always_comb begin
    if (brake)               target = BRK;
    else if (active == '0)   target = OFF;
    else if (active[MAG_W-1]) target = REV;
    else                     target = FWD;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      OFF: state_nxt = target;
      FWD, REV, BRK: begin
        if (target == OFF)        state_nxt = OFF;
        else if (target != state) state_nxt = DEAD;
      end
      // DEAD drives both pins low like OFF, so it always runs its full timer
      // and then takes whatever target is current, OFF included.
      DEAD: if (dead_cnt == '0) state_nxt = target;
      default: state_nxt = OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dead_cnt <= '0;
    end else if (state_nxt == DEAD && state != DEAD) begin
      dead_cnt <= DT_LOAD;
    end else if (state == DEAD && dead_cnt != '0) begin
      dead_cnt <= dead_cnt - 1'b1;
    end
  end

  // Outputs follow state_nxt so a direction change never lets the old pin
  // see one cycle of the new magnitude.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OFF;
      fwd   <= 1'b0;
      rev   <= 1'b0;
    end else begin
      state <= state_nxt;
      fwd   <= (state_nxt == FWD && pwm_on) || state_nxt == BRK;
      rev   <= (state_nxt == REV && pwm_on) || state_nxt == BRK;
    end
  end

endmodule

// File: rtl/pwm_mtr_drv.sv
// N-channel motor PWM driver: shared period counter plus one mtr_chan per motor.
// Optional per-period slew limit compiled in with SLEW_LIMIT_EN.
module pwm_mtr_drv
  import mtr_pkg::*;
#(
  parameter int NUM_MTR   = 2,
  parameter int MAG_W     = 11,
  parameter int DEAD_CYC  = 8,
  parameter int SLEW_STEP = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_MTR*MAG_W-1:0] drv,
  input  logic                     drv_vld,
  input  logic [NUM_MTR-1:0]       brake,
  output logic [NUM_MTR-1:0]       fwd,
  output logic [NUM_MTR-1:0]       rev,
  output logic                     period_done
);

  logic [MAG_W-2:0] cnt;
  logic             wrap;

  assign wrap = &cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      period_done <= 1'b0;
    end else begin
      cnt         <= cnt + 1'b1;
      period_done <= wrap;
    end
  end

  for (genvar i = 0; i < NUM_MTR; i++) begin : g_chan
    mtr_chan #(
      .MAG_W    (MAG_W),
      .DEAD_CYC (DEAD_CYC),
      .SLEW_STEP(SLEW_STEP)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .cnt    (cnt),
      .wrap   (wrap),
      .drv    (drv[i*MAG_W +: MAG_W]),
      .drv_vld(drv_vld),
      .brake  (brake[i]),
      .fwd    (fwd[i]),
      .rev    (rev[i])
    );
  end

endmodule

// File: tb/tb_pwm_mtr_drv.sv
// Self-checking bench for pwm_mtr_drv (NUM_MTR=2, MAG_W=11, DEAD_CYC=8).
// Duties are counted over one full PWM period; expectations go through a queue.
module tb_pwm_mtr_drv;

  localparam int NUM_MTR  = 2;
  localparam int MAG_W    = 11;
  localparam int DEAD_CYC = 8;
  localparam int PER      = 1024;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_MTR*MAG_W-1:0] drv = '0;
  logic                     drv_vld = 1'b0;
  logic [NUM_MTR-1:0]       brake = '0;
  logic [NUM_MTR-1:0]       fwd;
  logic [NUM_MTR-1:0]       rev;
  logic                     period_done;

  pwm_mtr_drv #(
    .NUM_MTR  (NUM_MTR),
    .MAG_W    (MAG_W),
    .DEAD_CYC (DEAD_CYC),
    .SLEW_STEP(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .drv        (drv),
    .drv_vld    (drv_vld),
    .brake      (brake),
    .fwd        (fwd),
    .rev        (rev),
    .period_done(period_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int f0; int r0; int f1; int r1; int o0; int o1;
  } exp_t;

  typedef struct {
    int         d0;
    int         d1;
    logic [1:0] brk;
    exp_t       e;
  } vec_t;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic set_drv(input int ch, input int val);
    drv[ch*MAG_W +: MAG_W] = MAG_W'(val);
  endtask

  task automatic strobe();
    drv_vld = 1'b1;
    @(negedge clk);
    drv_vld = 1'b0;
  endtask

  task automatic wait_pd();
    bit got = 1'b0;
    for (int i = 0; i < 2 * PER + 8; i++) begin
      @(negedge clk);
      if (period_done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("pd_timeout", int'(got), 1);
  endtask

  // Starts on the negedge where period_done is high; the next PER samples
  // cover cnt = 0 .. PER-1 of the freshly loaded period.
  task automatic measure(output exp_t m);
    m = '{default: 0};
    for (int i = 0; i < PER; i++) begin
      @(negedge clk);
      m.f0 += int'(fwd[0]);
      m.r0 += int'(rev[0]);
      m.f1 += int'(fwd[1]);
      m.r1 += int'(rev[1]);
      m.o0 += int'(fwd[0] & rev[0]);
      m.o1 += int'(fwd[1] & rev[1]);
    end
  endtask

  task automatic count_low0(output int n);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (fwd[0] || rev[0]) break;
      n++;
    end
  endtask

  task automatic cmp_exp(input string tag, input exp_t m, input exp_t e);
    check($sformatf("%s_fwd0", tag), m.f0, e.f0);
    check($sformatf("%s_rev0", tag), m.r0, e.r0);
    check($sformatf("%s_fwd1", tag), m.f1, e.f1);
    check($sformatf("%s_rev1", tag), m.r1, e.r1);
    check($sformatf("%s_ovl0", tag), m.o0, e.o0);
    check($sformatf("%s_ovl1", tag), m.o1, e.o1);
  endtask

  task automatic reset_and_first_pd(input string tag);
    int n;
    bit got;
    rst_n = 1'b1;
    check($sformatf("%s_fwd", tag), int'(fwd), 0);
    check($sformatf("%s_rev", tag), int'(rev), 0);
    check($sformatf("%s_pd", tag), int'(period_done), 0);
    n   = 0;
    got = 1'b0;
    for (int i = 0; i < 2 * PER; i++) begin
      @(negedge clk);
      n++;
      if (period_done) begin
        got = 1'b1;
        break;
      end
    end
    check($sformatf("%s_first_pd", tag), got ? n : -1, PER);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    exp_t m;
    exp_t e;
    int   n;
    int   hi;
`ifndef SLEW_LIMIT_EN
    vec_t tbl[10];
    tbl[0] = '{ 512,     0, 2'b00, '{ 512,    0,    0,    0,    0,    0}};
    tbl[1] = '{-256,     0, 2'b00, '{   0,  256,    0,    0,    0,    0}};
    tbl[2] = '{-256, -1024, 2'b00, '{   0,  256,    0, 1023,    0,    0}};
    tbl[3] = '{   0,  1023, 2'b00, '{   0,    0, 1023,    0,    0,    0}};
    tbl[4] = '{   1,    -1, 2'b00, '{   1,    0,    0,    1,    0,    0}};
    tbl[5] = '{ 300,     0, 2'b01, '{1024, 1024,    0,    0, 1024,    0}};
    tbl[6] = '{ 300,     0, 2'b00, '{ 300,    0,    0,    0,    0,    0}};
    tbl[7] = '{   0,     0, 2'b10, '{   0,    0, 1024, 1024,    0, 1024}};
    tbl[8] = '{-1023,    0, 2'b00, '{   0, 1023,    0,    0,    0,    0}};
    tbl[9] = '{   0,     0, 2'b00, '{   0,    0,    0,    0,    0,    0}};
`endif

    // Reset held for a few clocks, then released away from the edge.
    repeat (5) @(negedge clk);
    reset_and_first_pd("rst");

`ifndef SLEW_LIMIT_EN
    // Drive update is held off until the wrap, then shows one clock later.
    repeat (300) @(negedge clk);
    set_drv(0, 512);
    strobe();
    hi = 0;
    for (int i = 0; i < 2 * PER; i++) begin
      @(negedge clk);
      if (period_done) break;
      hi += int'(fwd[0] | rev[0]);
    end
    check("hold_until_wrap", hi, 0);
    @(negedge clk);
    check("first_clk_fwd0", int'(fwd[0]), 1);
    hi = 1;
    for (int i = 1; i < PER; i++) begin
      @(negedge clk);
      hi += int'(fwd[0]);
    end
    check("fwd512_duty", hi, 512);

    // Forward to reverse: DEAD_CYC low clocks after the wrap, then reverse.
    repeat (300) @(negedge clk);
    set_drv(0, -256);
    strobe();
    wait_pd();
    count_low0(n);
    check("dir_dead_len", n, DEAD_CYC);
    check("dir_dead_rev0", int'(rev[0]), 1);
    check("dir_dead_fwd0", int'(fwd[0]), 0);

    // Brake mid-period acts immediately through DEAD, release goes back via DEAD.
    set_drv(0, 300);
    strobe();
    wait_pd();
    wait_pd();
    repeat (50) @(negedge clk);
    check("pre_brake_fwd0", int'(fwd[0]), 1);
    brake[0] = 1'b1;
    count_low0(n);
    check("brk_dead_len", n, DEAD_CYC);
    check("brk_both_hi", int'(fwd[0] & rev[0]), 1);
    wait_pd();
    repeat (10) @(negedge clk);
    brake[0] = 1'b0;
    count_low0(n);
    check("unbrk_dead_len", n, DEAD_CYC);
    check("unbrk_fwd0", int'(fwd[0]), 1);
    check("unbrk_rev0", int'(rev[0]), 0);

    // Reset in the middle of a DEAD window clears outputs at once.
    brake[0] = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_dead_fwd", int'(fwd), 0);
    check("rst_dead_rev", int'(rev), 0);
    check("rst_dead_pd", int'(period_done), 0);
    brake[0] = 1'b0;
    repeat (3) @(negedge clk);
    reset_and_first_pd("rst2");

    // Two strobes in one period: the later word is the one applied.
    repeat (100) @(negedge clk);
    set_drv(0, 100);
    strobe();
    repeat (100) @(negedge clk);
    set_drv(0, 200);
    strobe();
    sb_q.push_back('{200, 0, 0, 0, 0, 0});
    wait_pd();
    measure(m);
    e = sb_q.pop_front();
    cmp_exp("last_wins", m, e);

    // Table: drive mid-period, skip the transition period, measure the next.
    foreach (tbl[k]) begin
      wait_pd();
      repeat (300) @(negedge clk);
      set_drv(0, tbl[k].d0);
      set_drv(1, tbl[k].d1);
      brake = tbl[k].brk;
      strobe();
      sb_q.push_back(tbl[k].e);
      wait_pd();
      wait_pd();
      measure(m);
      e = sb_q.pop_front();
      cmp_exp($sformatf("vec%0d", k), m, e);
    end
`else
    // Slew-limited ramp 0 -> +100 in steps of 16 per period.
    repeat (300) @(negedge clk);
    set_drv(0, 100);
    strobe();
    for (int k = 1; k <= 7; k++) begin
      sb_q.push_back('{(k < 7) ? 16 * k : 100, 0, 0, 0, 0, 0});
    end
    wait_pd();
    for (int k = 1; k <= 7; k++) begin
      measure(m);
      e = sb_q.pop_front();
      cmp_exp($sformatf("slew%0d", k), m, e);
    end
`endif

    check("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
